// File: rtl/jtcontra_snd_cmd.sv
// Main-to-sound CPU command path: a small FIFO feeding an 8-bit latch, with an
// IRQ pulse per command and a wait for the sound CPU to read it (or time out).
//
// state | meaning
// IDLE  | no command in flight, waiting for the FIFO to hold an entry
// LOAD  | pop FIFO head into snd_latch, clear counter (one cycle)
// PULSE | snd_irq high, count PULSE_LEN cen ticks
// WAIT  | snd_irq low, wait for a latch read edge or TIMEOUT cen ticks
// GAP   | forced low cycle so consecutive IRQs always show a rising edge
module jtcontra_snd_cmd #(
  parameter int AW        = 2,
  parameter int PULSE_LEN = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cmd_we,
  input  logic [7:0] cmd_din,
  input  logic       latch_rd,
  input  logic       clr_ovf,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       ovf
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] DEPTH_C  = DEPTH[AW:0];
  localparam logic [15:0] PULSE_TC = 16'(PULSE_LEN - 1);
  localparam logic [15:0] WAIT_TC  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    WAIT,
    GAP
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nx;
  logic          push, pop, drop;
  logic [15:0]   cnt, cnt_nx;
  logic          lrd_q, lrd_edge;

  // A pop in LOAD frees a slot in the same cycle, so a push into a full FIFO
  // is still accepted then.
  assign pop      = (state == LOAD);
  assign push     = cmd_we && ((count != DEPTH_C) || pop);
  assign drop     = cmd_we && !push;
  assign lrd_edge = latch_rd && !lrd_q;

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  // Storage is deliberately left out of reset; only pointers and count clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nx;
      fifo_full  <= (count_nx == DEPTH_C);
      fifo_empty <= (count_nx == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end
  end

  // The counter only advances on cen and always exits at its terminal count.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (count != '0) state_nx = LOAD;
      end
      LOAD: begin
        cnt_nx   = '0;
        state_nx = PULSE;
      end
      PULSE: begin
        if (cen) begin
          if (cnt == PULSE_TC) begin
            cnt_nx   = '0;
            state_nx = WAIT;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
      end
      WAIT: begin
        if (lrd_edge) begin
          state_nx = GAP;
        end else if (cen) begin
          if (cnt == WAIT_TC) state_nx = GAP;
          else                cnt_nx   = cnt + 16'd1;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lrd_q     <= 1'b0;
      snd_irq   <= 1'b0;
      snd_latch <= 8'h00;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lrd_q   <= latch_rd;
      snd_irq <= (state_nx == PULSE);
      if (pop) snd_latch <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_jtcontra_snd_cmd.sv
// Directed bench for jtcontra_snd_cmd: a queue-based model checked every cycle,
// plus hand-computed timing and value checks for each scenario.
module tb_jtcontra_snd_cmd;

  localparam int AW        = 2;
  localparam int PULSE_LEN = 8;
  localparam int TIMEOUT   = 16;
  localparam int DEPTH     = 1 << AW;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       cen      = 1'b1;
  logic       cmd_we   = 1'b0;
  logic [7:0] cmd_din  = 8'h00;
  logic       latch_rd = 1'b0;
  logic       clr_ovf  = 1'b0;
  logic [7:0] snd_latch;
  logic       snd_irq, fifo_full, fifo_empty, ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  jtcontra_snd_cmd #(.AW(AW), .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .cmd_we     (cmd_we),
    .cmd_din    (cmd_din),
    .latch_rd   (latch_rd),
    .clr_ovf    (clr_ovf),
    .snd_latch  (snd_latch),
    .snd_irq    (snd_irq),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 load, 2 pulse, 3 wait, 4 gap; m_left counts remaining cen ticks
  logic [7:0] mq[$];
  logic [7:0] m_latch;
  logic       m_irq, m_ovf, m_lrd;
  int         m_phase, m_left, m_sz;
  bit         m_pop, m_edge;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_phase = 0; m_left = 0;
      m_latch = 8'h00; m_irq = 1'b0; m_ovf = 1'b0; m_lrd = 1'b0;
    end else begin
      m_sz   = mq.size();
      m_pop  = (m_phase == 1);
      m_edge = latch_rd && !m_lrd;
      m_lrd  = latch_rd;
      case (m_phase)
        0: if (m_sz > 0) m_phase = 1;
        1: begin m_latch = mq.pop_front(); m_phase = 2; m_left = PULSE_LEN; end
        2: if (cen) begin
             m_left--;
             if (m_left == 0) begin m_phase = 3; m_left = TIMEOUT; end
           end
        3: if (m_edge) m_phase = 4;
           else if (cen) begin
             m_left--;
             if (m_left == 0) m_phase = 4;
           end
        default: m_phase = 0;
      endcase
      if (cmd_we && (m_sz < DEPTH || m_pop)) mq.push_back(cmd_din);
      if (clr_ovf) m_ovf = 1'b0;
      else if (cmd_we && m_sz == DEPTH && !m_pop) m_ovf = 1'b1;
      m_irq = (m_phase == 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("snd_irq",    32'(snd_irq),    32'(m_irq));
      check("snd_latch",  32'(snd_latch),  32'(m_latch));
      check("fifo_full",  32'(fifo_full),  32'(mq.size() == DEPTH));
      check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
      check("ovf",        32'(ovf),        32'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  bit         cen_div3 = 1'b0;
  bit         cen_lvl  = 1'b1;
  bit         resp_en  = 1'b0;
  int         resp_dly = 2;
  int         resp_at  = -1;
  logic       irq_prev = 1'b0;
  logic [7:0] rise_vals[$];
  int         rise_cyc[$];
  int         fall_cyc[$];
  int         tick_cyc[$];

  task automatic clear_logs();
    rise_vals.delete(); rise_cyc.delete(); fall_cyc.delete(); tick_cyc.delete();
  endtask

  // One clock: log IRQ edges and sampled cen ticks, answer pulses if enabled.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (cen) tick_cyc.push_back(cyc);
    cmd_we = 1'b0; clr_ovf = 1'b0; latch_rd = 1'b0;
    if (snd_irq === 1'b1 && irq_prev === 1'b0) begin
      rise_vals.push_back(snd_latch); rise_cyc.push_back(cyc);
    end
    if (snd_irq !== 1'b1 && irq_prev === 1'b1) begin
      fall_cyc.push_back(cyc);
      if (resp_en) resp_at = cyc + resp_dly;
    end
    if (resp_en && cyc == resp_at) latch_rd = 1'b1;
    irq_prev = snd_irq;
    cen = cen_div3 ? ((cyc + 1) % 3 == 0) : cen_lvl;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [7:0] b);
    cmd_we = 1'b1; cmd_din = b; step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int pc, e0, n0, f, r1, f1, n_hi, k, t24;

    step();
    chk_en = 1'b1;
    run(2);
    check("rst_irq",   32'(snd_irq),    32'h0);
    check("rst_latch", 32'(snd_latch),  32'h00);
    check("rst_empty", 32'(fifo_empty), 32'h1);
    check("rst_full",  32'(fifo_full),  32'h0);
    check("rst_ovf",   32'(ovf),        32'h0);
    rst_n = 1'b1;
    run(2);

    // single command, latch read 20 cycles after the push
    clear_logs();
    pc = cyc;
    push(8'h5A);
    e0 = cyc;
    check("single_empty_low", 32'(fifo_empty), 32'h0);
    while (cyc < pc + 20) step();
    latch_rd = 1'b1;
    run(15);
    check("single_rises", rise_cyc.size(), 1);
    if (rise_cyc.size() >= 1 && fall_cyc.size() >= 1) begin
      check("single_rise_delay", rise_cyc[0] - e0, 2);
      check("single_high_len",   fall_cyc[0] - rise_cyc[0], PULSE_LEN);
      check("single_latch_val",  32'(rise_vals[0]), 32'h5A);
    end
    check("single_empty_end", 32'(fifo_empty), 32'h1);
    check("single_latch_hold", 32'(snd_latch), 32'h5A);

    // burst of three, each pulse answered two cycles after it falls
    clear_logs();
    resp_en = 1'b1; resp_dly = 2;
    push(8'h01); push(8'h02); push(8'h03);
    run(80);
    resp_en = 1'b0; resp_at = -1;
    check("burst_rises", rise_vals.size(), 3);
    if (rise_vals.size() == 3 && fall_cyc.size() >= 2) begin
      check("burst_val0", 32'(rise_vals[0]), 32'h01);
      check("burst_val1", 32'(rise_vals[1]), 32'h02);
      check("burst_val2", 32'(rise_vals[2]), 32'h03);
      check("burst_gap0", rise_cyc[1] - fall_cyc[0], 6);
      check("burst_gap1", rise_cyc[2] - fall_cyc[1], 6);
    end

    // overflow with the sound side frozen (no cen, no latch reads)
    cen_lvl = 1'b0;
    step();
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    check("ovf_full",  32'(fifo_full), 32'h1);
    check("ovf_set",   32'(ovf),       32'h1);
    check("ovf_latch", 32'(snd_latch), 32'h10);
    check("ovf_irq",   32'(snd_irq),   32'h1);
    clr_ovf = 1'b1;
    step();
    check("ovf_clr", 32'(ovf), 32'h0);

    // push into a full FIFO in the LOAD cycle
    cen_lvl = 1'b1;
    n0 = fall_cyc.size();
    for (int i = 0; i < 60 && fall_cyc.size() == n0; i++) step();
    check("sim_fall_seen", fall_cyc.size(), n0 + 1);
    f = cyc;
    latch_rd = 1'b1;
    run(3);
    check("sim_pre_full", 32'(fifo_full), 32'h1);
    push(8'h20);
    check("sim_cycles",  cyc - f, 4);
    check("sim_full",    32'(fifo_full), 32'h1);
    check("sim_ovf",     32'(ovf),       32'h0);
    check("sim_irq",     32'(snd_irq),   32'h1);
    check("sim_latch",   32'(snd_latch), 32'h11);
    clear_logs();
    resp_en = 1'b1;
    run(100);
    resp_en = 1'b0; resp_at = -1;
    check("drain_rises", rise_vals.size(), 4);
    if (rise_vals.size() == 4) begin
      check("drain_val0", 32'(rise_vals[0]), 32'h12);
      check("drain_val1", 32'(rise_vals[1]), 32'h13);
      check("drain_val2", 32'(rise_vals[2]), 32'h14);
      check("drain_val3", 32'(rise_vals[3]), 32'h20);
    end
    check("drain_empty", 32'(fifo_empty), 32'h1);

    // timeout with cen every third cycle; a latch read during PULSE is ignored
    cen_div3 = 1'b1;
    step();
    clear_logs();
    push(8'hA1); push(8'hA2);
    for (int i = 0; i < 300 && rise_cyc.size() < 2; i++) begin
      step();
      if (rise_cyc.size() == 1 && cyc == rise_cyc[0] + 2) latch_rd = 1'b1;
    end
    check("to_rises", rise_cyc.size(), 2);
    if (rise_cyc.size() == 2 && fall_cyc.size() >= 1) begin
      r1 = rise_cyc[0]; f1 = fall_cyc[0];
      n_hi = 0; k = 0; t24 = -1;
      foreach (tick_cyc[i]) begin
        if (tick_cyc[i] > r1 && tick_cyc[i] <= f1) n_hi++;
        if (tick_cyc[i] > r1) begin
          k++;
          if (k == PULSE_LEN + TIMEOUT) t24 = tick_cyc[i];
        end
      end
      check("to_pulse_ticks", n_hi, PULSE_LEN);
      check("to_rise2_cycle", rise_cyc[1], t24 + 3);
      check("to_val0", 32'(rise_vals[0]), 32'hA1);
      check("to_val1", 32'(rise_vals[1]), 32'hA2);
    end
    run(120);
    cen_div3 = 1'b0; cen_lvl = 1'b1;
    step();

    // reset during PULSE drops IRQ at once and discards the queue
    clear_logs();
    push(8'h77); push(8'h78);
    for (int i = 0; i < 10 && snd_irq !== 1'b1; i++) step();
    check("rst_mid_irq_before", 32'(snd_irq), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_irq",   32'(snd_irq),    32'h0);
    check("rst_mid_latch", 32'(snd_latch),  32'h00);
    check("rst_mid_empty", 32'(fifo_empty), 32'h1);
    run(3);
    rst_n = 1'b1;
    clear_logs();
    run(40);
    check("rst_no_pulse", rise_cyc.size(), 0);
    check("rst_empty_after", 32'(fifo_empty), 32'h1);
    push(8'h99);
    run(20);
    check("rst_new_pulse", rise_vals.size(), 1);
    if (rise_vals.size() == 1) check("rst_new_val", 32'(rise_vals[0]), 32'h99);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
